// File: rtl/mbist_diag_log.sv
// ============================================================================
// mbist_diag_log : MBIST fail logger (FWFT fail log, fail counter, verdict)
// Optional build macro MBIST_DIAG_DEDUP_EN suppresses repeated identical pushes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mbist_diag_log #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8,
    parameter int LOG_DEPTH  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  b_clk,
    input  logic                  b_rst_n,
    input  logic                  b_te,
    input  logic                  b_fail,
    input  logic [ADDR_WIDTH-1:0] mon_addr,
    input  logic [DATA_WIDTH-1:0] mon_exp,
    input  logic [DATA_WIDTH-1:0] mon_act,
    input  logic                  log_pop,
    output logic                  log_vld,
    output logic [ADDR_WIDTH-1:0] log_addr,
    output logic [DATA_WIDTH-1:0] log_syn,
    output logic                  log_full,
    output logic                  log_ovf,
    output logic [CNT_WIDTH-1:0]  fail_cnt,
    output logic [1:0]            diag_state,
    output logic                  diag_pass
);

    localparam int c_ptr_w = $clog2(LOG_DEPTH);
    localparam int c_ent_w = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [c_ptr_w:0] c_full = (c_ptr_w+1)'(LOG_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_BAD  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_clear;
    logic                  r_te_d;
    logic                  r_stg_vld;
    logic [ADDR_WIDTH-1:0] r_stg_addr;
    logic [DATA_WIDTH-1:0] r_stg_syn;
    logic [c_ptr_w-1:0]    r_wptr;
    logic [c_ptr_w-1:0]    r_rptr;
    logic [c_ptr_w:0]      r_count;
    logic [c_ent_w-1:0]    r_mem [LOG_DEPTH];
    logic [CNT_WIDTH-1:0]  r_fail_cnt;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic                  r_ovf;
    logic                  r_pass;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_fail_q;
    logic                  w_dup;
    logic                  w_push_req;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic [c_ent_w-1:0]    w_head;
    logic [c_ent_w-1:0]    w_stg_ent;

    assign w_rise    = b_te & ~r_te_d;
    assign w_fall    = ~b_te & r_te_d;
    assign w_fail_q  = b_fail & r_stg_vld & (r_state == ST_RUN);
    assign w_stg_ent = {r_stg_addr, r_stg_syn};
    assign w_full    = (r_count == c_full);
    assign w_pop     = log_pop & (r_count != '0);

`ifdef MBIST_DIAG_DEDUP_EN
    logic               r_last_vld;
    logic [c_ent_w-1:0] r_last_ent;

    assign w_dup = r_last_vld & (r_last_ent == w_stg_ent);

    always_ff @(posedge b_clk or negedge b_rst_n) begin
        if (!b_rst_n) begin
            r_last_vld <= 1'b0;
            r_last_ent <= '0;
        end else if (w_clear) begin
            r_last_vld <= 1'b0;
            r_last_ent <= '0;
        end else if (w_push) begin
            r_last_vld <= 1'b1;
            r_last_ent <= w_stg_ent;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    assign w_push_req = w_fail_q & ~w_dup;
    // A pop in the same cycle frees the slot a full log needs for this push.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_cnt_nxt  = (w_fail_q && (r_fail_cnt != '1)) ? r_fail_cnt + CNT_WIDTH'(1)
                                                         : r_fail_cnt;

    always_ff @(posedge b_clk or negedge b_rst_n) begin
        if (!b_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_RUN;
                    w_clear     = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_fall) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (w_rise) begin
                    w_state_nxt = ST_RUN;
                    w_clear     = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Stage aligns monitor data with the engine's one-cycle-late fail flag.
    always_ff @(posedge b_clk or negedge b_rst_n) begin
        if (!b_rst_n) begin
            r_te_d     <= 1'b0;
            r_stg_vld  <= 1'b0;
            r_stg_addr <= '0;
            r_stg_syn  <= '0;
        end else begin
            r_te_d <= b_te;
            if (b_te) begin
                r_stg_vld  <= 1'b1;
                r_stg_addr <= mon_addr;
                r_stg_syn  <= mon_exp ^ mon_act;
            end else begin
                r_stg_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge b_clk or negedge b_rst_n) begin
        if (!b_rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_fail_cnt <= '0;
            r_ovf      <= 1'b0;
            r_pass     <= 1'b0;
        end else if (w_clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_fail_cnt <= '0;
            r_ovf      <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_fail_cnt <= w_cnt_nxt;
            if (w_push) r_wptr <= r_wptr + c_ptr_w'(1);
            if (w_pop)  r_rptr <= r_rptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
            // Uses the next count so a fail in the falling-edge cycle still fails the session.
            if (r_state == ST_RUN && w_fall) r_pass <= (w_cnt_nxt == '0);
        end
    end

    always_ff @(posedge b_clk or negedge b_rst_n) begin
        if (!b_rst_n) begin
            for (int i = 0; i < LOG_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wptr] <= w_stg_ent;
        end
    end

    assign w_head     = r_mem[r_rptr];
    assign log_addr   = w_head[c_ent_w-1:DATA_WIDTH];
    assign log_syn    = w_head[DATA_WIDTH-1:0];
    assign log_vld    = (r_count != '0);
    assign log_full   = w_full;
    assign log_ovf    = r_ovf;
    assign fail_cnt   = r_fail_cnt;
    assign diag_state = r_state;
    assign diag_pass  = r_pass;

endmodule

`default_nettype wire

// File: doc/mbist_diag_log.md
# mbist_diag_log

Diagnostic fail logger that sits directly downstream of the 8Kx8 SRAM MBIST engine.
- Consumes the engine's registered fail flag and the per-cycle test address, expected pattern and SRAM read data.
- Captures each failing address and its bit syndrome into a small first-word-fall-through log, counts total fails, and reports a per-session pass/fail verdict.
- Software or a test-access port drains the log through a pop handshake after the BIST session ends.

## Interface
Parameters:
- ADDR_WIDTH, 13, SRAM address width
- DATA_WIDTH, 8, SRAM data width
- LOG_DEPTH, 8, number of log entries; power of two, minimum 2
- CNT_WIDTH, 16, width of the saturating fail counter

Ports:
- b_clk  in  1  clock
- b_rst_n  in  1  reset, asynchronous, active-low
- b_te  in  1  BIST test enable; level defines a session
- b_fail  in  1  registered compare-fail flag from the MBIST engine
- mon_addr  in  ADDR_WIDTH  test address presented to the SRAM this cycle
- mon_exp  in  DATA_WIDTH  expected test pattern this cycle
- mon_act  in  DATA_WIDTH  SRAM read data this cycle
- log_pop  in  1  pop the head entry
- log_vld  out  1  head entry valid (log not empty)
- log_addr  out  ADDR_WIDTH  head entry failing address
- log_syn  out  DATA_WIDTH  head entry syndrome (exp XOR act)
- log_full  out  1  all LOG_DEPTH entries occupied
- log_ovf  out  1  sticky; a fail was dropped because the log was full
- fail_cnt  out  CNT_WIDTH  fail cycles counted this session; saturating
- diag_state  out  2  session state: 0 IDLE, 1 RUN, 2 DONE
- diag_pass  out  1  valid in DONE; 1 when fail_cnt == 0

## Operation
- Alignment stage:
  - When b_te=1, mon_addr and mon_exp^mon_act are registered into stg_addr/stg_syn, and stg_vld <= 1.
  - When b_te=0, stg_vld <= 0.
  - b_fail in cycle N is paired with the stage contents from cycle N-1.
- Qualified fail: fail_q = b_fail & stg_vld & (diag_state==RUN).
- Session FSM; te_d is b_te registered:
  - IDLE -> RUN on b_te & ~te_d. This transition clears the log pointers, fail_cnt, log_ovf and the dedup register.
  - RUN -> DONE on ~b_te & te_d.
  - DONE -> RUN on the next rising b_te, which clears the log state again.
  - State 3 is illegal and recovers to IDLE.
- Fail handling in RUN, on each fail_q cycle:
  - fail_cnt increments, saturating at all-ones.
  - An entry {stg_addr, stg_syn} is pushed if the log is not full.
  - If the log is full and no pop occurs in the same cycle, the entry is dropped and log_ovf is set.
- Log:
  - Circular buffer with a (log2(LOG_DEPTH)+1)-bit occupancy count.
  - Head entry is presented combinationally from storage.
  - log_vld = (count != 0); log_full = (count == LOG_DEPTH).
- Pop:
  - log_pop with log_vld=1 advances the read pointer.
  - log_pop with log_vld=0 is ignored with no state change.
  - Pops are honoured in every state.
- Simultaneous push and pop:
  - Both are performed and count is unchanged.
  - When full, this is not an overflow.
  - When empty, only the push takes effect, because the pop is ignored.
- Pointers wrap modulo LOG_DEPTH.

## Timing
- Reset values:
  - diag_state=IDLE; all other outputs 0.
  - log_addr and log_syn read 0 because storage is reset.
- Fail-to-visibility latency:
  - Monitor data sampled in cycle N-1 and b_fail=1 in cycle N produce the push on the edge ending cycle N.
  - log_vld and fail_cnt update in cycle N+1.
- A pop takes effect on the clock edge; the new head is visible the next cycle.
- diag_pass is registered on the RUN->DONE transition and is valid from the first DONE cycle.
- When b_te falls, the b_fail that arrives in the first cycle after the fall is discarded because the state is already DONE.
- Asserting b_rst_n low mid-session returns everything to reset values immediately, independent of the clock.

## Configuration
- MBIST_DIAG_DEDUP_EN defined:
  - A fail_q whose {stg_addr, stg_syn} equals the last pushed entry of the session is counted in fail_cnt but not pushed.
  - A dedup match never sets log_ovf.
  - The last-pushed register is cleared at session start; its first comparison is marked invalid.
- MBIST_DIAG_DEDUP_EN undefined:
  - Every fail_q cycle is pushed, subject to the full and overflow rules.

## Test plan
- Clean session: b_te high for 100 cycles, b_fail=0 -> after the fall, diag_state=2, diag_pass=1, fail_cnt=0, log_vld=0.
- Single fail: mon_addr=0x1ABC, mon_exp=0xFF, mon_act=0xF7 in cycle N-1, b_fail=1 in cycle N -> log_addr=0x1ABC, log_syn=0x08, fail_cnt=1; one pop -> log_vld=0.
- Overflow: 10 fails at distinct addresses, LOG_DEPTH=8 -> log_full=1, log_ovf=1, fail_cnt=10; the 8 pops return addresses in arrival order.
- Push and pop at full: log full, fail_q and log_pop in the same cycle -> count stays 8, log_ovf stays 0, head advances.
- Dedup: b_fail high for 3 cycles with the same address and syndrome -> with MBIST_DIAG_DEDUP_EN, 1 entry and fail_cnt=3; without it, 3 entries.
- Reset mid-RUN with 4 entries logged -> all outputs at reset values; a new rising b_te starts from an empty log.
